// File: rtl/noc_ep_inject_arbiter.sv
// rtl/noc_ep_inject_arbiter.sv - packet-atomic round-robin injection arbiter with per-VC credit tracking
module noc_ep_inject_arbiter #(
    parameter int NOC_ID = 0,
    parameter int N_REQ  = 4,
    parameter int V      = 2,
    parameter int Fw     = 32,
    parameter int LB     = 4,
    localparam int Vw    = (V > 1) ? $clog2(V) : 1,
    localparam int Rw    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int Cw    = $clog2(LB + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ*Fw-1:0] req_flit_all,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_hdr,
    input  logic [N_REQ-1:0]    req_tail,
    input  logic [N_REQ*Vw-1:0] req_vc_all,
    output logic [N_REQ-1:0]    req_ready,
    output logic [Fw-1:0]       flit_out,
    output logic                flit_out_wr,
    output logic [V-1:0]        flit_out_vc,
    input  logic [V-1:0]        credit_in,
    output logic                busy,
    output logic [Rw-1:0]       owner,
    output logic                err
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [Cw-1:0] CRED_MAX = Cw'(LB);

    state_t          state, state_n;
    logic [Rw-1:0]   rr_ptr;
    logic [Rw-1:0]   owner_r;
    logic [Vw-1:0]   cur_vc;
    logic            hdr_done;
    logic [Cw-1:0]   credit [V];
    logic [V-1:0]    cred_ok;
    logic [V-1:0]    cur_onehot;
    logic [V-1:0]    dec_vc;
    logic [V-1:0]    sat_vc;
    logic [N_REQ-1:0] eligible;
    logic            grant;
    logic [Rw-1:0]   winner;
    logic [Vw-1:0]   win_vc;
    logic            own_valid;
    logic            own_hdr;
    logic            own_tail;
    logic [Fw-1:0]   own_flit;
    logic            cur_ok;
    logic            accept;
    logic            unused_noc_id;

    assign unused_noc_id = (NOC_ID < 0);

    always_comb begin
        for (int v = 0; v < V; v++) begin
            cred_ok[v]    = (credit[v] != '0);
            cur_onehot[v] = (cur_vc == Vw'(v));
        end
    end

    assign cur_ok = |(cred_ok & cur_onehot);

    // A header is eligible only if its target VC has at least one credit
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = 1'b0;
            for (int v = 0; v < V; v++) begin
                if (req_vc_all[Vw*i +: Vw] == Vw'(v)) begin
                    eligible[i] = req_valid[i] && req_hdr[i] && cred_ok[v];
                end
            end
        end
    end

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment
    always_comb begin
        logic [Rw:0]   sum;
        logic [Rw-1:0] idx;
        grant  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (Rw+1)'(k);
            if (sum >= (Rw+1)'(N_REQ)) begin
                sum = sum - (Rw+1)'(N_REQ);
            end
            idx = sum[Rw-1:0];
            if (eligible[idx]) begin
                grant  = (state == IDLE);
                winner = idx;
            end
        end
    end

    always_comb begin
        win_vc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == Rw'(i)) begin
                win_vc = req_vc_all[Vw*i +: Vw];
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_hdr   = 1'b0;
        own_tail  = 1'b0;
        own_flit  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_r == Rw'(i)) begin
                own_valid = req_valid[i];
                own_hdr   = req_hdr[i];
                own_tail  = req_tail[i];
                own_flit  = req_flit_all[Fw*i +: Fw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (grant) state_n = SEND;
            SEND: if (accept && own_tail) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state == SEND) begin
            accept = own_valid && cur_ok;
            for (int i = 0; i < N_REQ; i++) begin
                if (owner_r == Rw'(i)) begin
                    req_ready[i] = accept;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            owner_r  <= '0;
            cur_vc   <= '0;
            hdr_done <= 1'b0;
        end else if (grant) begin
            owner_r  <= winner;
            cur_vc   <= win_vc;
            rr_ptr   <= (winner == Rw'(N_REQ - 1)) ? '0 : winner + Rw'(1);
            hdr_done <= 1'b0;
        end else if (accept) begin
            hdr_done <= 1'b1;
        end
    end

    always_comb begin
        for (int v = 0; v < V; v++) begin
            dec_vc[v] = accept && cur_onehot[v];
            sat_vc[v] = credit_in[v] && !dec_vc[v] && (credit[v] == CRED_MAX);
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (reset) begin
                credit[v] <= CRED_MAX;
            end else if (credit_in[v] && !dec_vc[v] && !sat_vc[v]) begin
                credit[v] <= credit[v] + Cw'(1);
            end else if (dec_vc[v] && !credit_in[v]) begin
                credit[v] <= credit[v] - Cw'(1);
            end
        end
    end

    // A second header from the owner is flagged but still forwarded
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((|sat_vc) || (state == SEND && own_valid && own_hdr && hdr_done)) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
            flit_out_vc <= '0;
        end else begin
            flit_out_wr <= accept;
            flit_out_vc <= accept ? cur_onehot : '0;
            if (accept) begin
                flit_out <= own_flit;
            end
        end
    end

    assign busy  = (state == SEND);
    assign owner = owner_r;

endmodule
